// File: rtl/mdio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_ctrl
//  Description : Clause-22 MDIO master; turns single register read/write
//                requests into MDC/MDIO management frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdio_ctrl #(
  parameter int CLK_DIV     = 32,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        reqValidIn,
  output logic        reqReadyOut,
  input  logic        reqWrIn,
  input  logic [4:0]  reqPhyAddrIn,
  input  logic [4:0]  reqRegAddrIn,
  input  logic [15:0] reqWrDataIn,
  output logic [15:0] rdDataOut,
  output logic        rdDataValidOut,
  output logic        rdErrOut,
  output logic        busyOut,
  output logic        mdClkOut,
  output logic        mdioOut,
  output logic        mdioOeOut,
  input  logic        mdioIn
);

  localparam int                c_divW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_divW-1:0] c_divLast = c_divW'(CLK_DIV - 1);

  localparam logic [2:0] c_stIdle    = 3'd0;
  localparam logic [2:0] c_stPre     = 3'd1;
  localparam logic [2:0] c_stHdr     = 3'd2;
  localparam logic [2:0] c_stTa      = 3'd3;
  localparam logic [2:0] c_stData    = 3'd4;
  localparam logic [2:0] c_stIdleBit = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_nextState;
  logic [4:0]        r_bitCnt;
  logic [c_divW-1:0] r_divCnt;
  logic              r_high;
  logic              r_ready;
  logic              r_wr;
  logic [4:0]        r_phyAddr;
  logic [4:0]        r_regAddr;
  logic [15:0]       r_wrData;
  logic [15:0]       r_rxShift;
  logic              r_taErr;
  logic [15:0]       r_rdData;
  logic              r_rdValid;
  logic              r_rdErr;
  logic              r_sync1;
  logic              r_sync2;
  logic              w_accept;
  logic              w_lowLast;
  logic              w_bitEnd;
  logic [13:0]       w_hdr;
  logic              w_mdioOut;
  logic              w_mdioOe;

  assign w_accept  = reqValidIn & r_ready;
  assign w_lowLast = ~r_high & (r_divCnt == c_divLast);
  assign w_bitEnd  =  r_high & (r_divCnt == c_divLast);

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) r_state <= c_stIdle;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_stIdle:    if (w_accept) w_nextState = PREAMBLE_EN ? c_stPre : c_stHdr;
      c_stPre:     if (w_bitEnd && r_bitCnt == 5'd31) w_nextState = c_stHdr;
      c_stHdr:     if (w_bitEnd && r_bitCnt == 5'd13) w_nextState = c_stTa;
      c_stTa:      if (w_bitEnd && r_bitCnt == 5'd1)  w_nextState = c_stData;
      c_stData:    if (w_bitEnd && r_bitCnt == 5'd15) w_nextState = c_stIdleBit;
      c_stIdleBit: if (w_bitEnd) w_nextState = c_stIdle;
      default:     w_nextState = c_stIdle;
    endcase
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_bitCnt  <= 5'd0;
      r_divCnt  <= '0;
      r_high    <= 1'b0;
      r_ready   <= 1'b0;
      r_wr      <= 1'b0;
      r_phyAddr <= 5'd0;
      r_regAddr <= 5'd0;
      r_wrData  <= 16'h0000;
      r_rxShift <= 16'h0000;
      r_taErr   <= 1'b0;
      r_rdData  <= 16'h0000;
      r_rdValid <= 1'b0;
      r_rdErr   <= 1'b0;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
    end else begin
      r_ready   <= (w_nextState == c_stIdle);
      r_rdValid <= 1'b0;
      r_sync1   <= mdioIn;
      r_sync2   <= r_sync1;
      if (w_accept) begin
        r_wr      <= reqWrIn;
        r_phyAddr <= reqPhyAddrIn;
        r_regAddr <= reqRegAddrIn;
        r_wrData  <= reqWrDataIn;
        r_bitCnt  <= 5'd0;
        r_divCnt  <= '0;
        r_high    <= 1'b0;
        r_taErr   <= 1'b0;
      end else if (r_state != c_stIdle) begin
        if (r_divCnt == c_divLast) begin
          r_divCnt <= '0;
          r_high   <= ~r_high;
        end else begin
          r_divCnt <= r_divCnt + 1'b1;
        end
        if (w_bitEnd)
          r_bitCnt <= (w_nextState != r_state) ? 5'd0 : r_bitCnt + 5'd1;
        // Read sampling happens just before MDC rises, after the synchronizer settles
        if (w_lowLast && !r_wr) begin
          if (r_state == c_stTa && r_bitCnt == 5'd1) r_taErr <= r_sync2;
          if (r_state == c_stData) r_rxShift <= {r_rxShift[14:0], r_sync2};
        end
        if (w_bitEnd && r_state == c_stIdleBit && !r_wr) begin
          r_rdData  <= r_rxShift;
          r_rdErr   <= r_taErr;
          r_rdValid <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_hdr     = {2'b01, (r_wr ? 2'b01 : 2'b10), r_phyAddr, r_regAddr};
    w_mdioOut = 1'b1;
    w_mdioOe  = 1'b0;
    case (r_state)
      c_stPre: w_mdioOe = 1'b1;
      c_stHdr: begin
        w_mdioOe  = 1'b1;
        w_mdioOut = w_hdr[4'd13 - r_bitCnt[3:0]];
      end
      c_stTa: begin
        w_mdioOe  = r_wr;
        w_mdioOut = r_wr ? ~r_bitCnt[0] : 1'b1;
      end
      c_stData: begin
        w_mdioOe  = r_wr;
        w_mdioOut = r_wr ? r_wrData[4'd15 - r_bitCnt[3:0]] : 1'b1;
      end
      default: ;
    endcase
  end

  assign mdioOut        = w_mdioOut;
  assign mdioOeOut      = w_mdioOe;
  assign mdClkOut       = r_high;
  assign busyOut        = (r_state != c_stIdle);
  assign reqReadyOut    = r_ready;
  assign rdDataOut      = r_rdData;
  assign rdDataValidOut = r_rdValid;
  assign rdErrOut       = r_rdErr;

endmodule
`default_nettype wire

// File: tb/tb_mdio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdio_ctrl
//  Description : Self-checking bench for mdio_ctrl with a Clause-22 PHY model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_ctrl;
  localparam int DIV_A = 4;
  localparam int DIV_B = 5;
  localparam int NA = 65 * 2 * DIV_A;
  localparam int NB = 33 * 2 * DIV_B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic validA, readyA, wrA, rvA, errA, busyA, mdcA, outA, oeA;
  logic [4:0] phyA, regA;
  logic [15:0] wdA, rdA;
  logic mdioInA = 1'b1;
  logic validB, readyB, wrB, rvB, errB, busyB, mdcB, outB, oeB;
  logic [4:0] phyB, regB;
  logic [15:0] wdB, rdB;
  logic mdioInB = 1'b1;

  mdio_ctrl #(.CLK_DIV(DIV_A), .PREAMBLE_EN(1'b1)) dutA (
    .clkIn(clk), .rstIn(rst), .reqValidIn(validA), .reqReadyOut(readyA),
    .reqWrIn(wrA), .reqPhyAddrIn(phyA), .reqRegAddrIn(regA), .reqWrDataIn(wdA),
    .rdDataOut(rdA), .rdDataValidOut(rvA), .rdErrOut(errA), .busyOut(busyA),
    .mdClkOut(mdcA), .mdioOut(outA), .mdioOeOut(oeA), .mdioIn(mdioInA));

  mdio_ctrl #(.CLK_DIV(DIV_B), .PREAMBLE_EN(1'b0)) dutB (
    .clkIn(clk), .rstIn(rst), .reqValidIn(validB), .reqReadyOut(readyB),
    .reqWrIn(wrB), .reqPhyAddrIn(phyB), .reqRegAddrIn(regB), .reqWrDataIn(wdB),
    .rdDataOut(rdB), .rdDataValidOut(rvB), .rdErrOut(errB), .busyOut(busyB),
    .mdClkOut(mdcB), .mdioOut(outB), .mdioOeOut(oeB), .mdioIn(mdioInB));

  int nChecks = 0;
  int nPass = 0;
  bit phyOn = 1'b0;
  logic phyTa = 1'b0;
  logic [15:0] phyData = 16'h0;
  logic [15:0] mdlRd = 16'h0;
  logic [1:0] capA[$];
  logic [1:0] capB[$];
  int edgeA = 0;
  int validCntA = 0;
  int validCntB = 0;
  logic prevA = 1'b0;
  logic prevB = 1'b0;
  time tAcc = 0;

  // PHY model: value the PHY presents for frame bit idx (pull-up when not driving)
  function automatic logic phyBit(input int idx);
    if (!phyOn) return 1'b1;
    if (idx == 47) return phyTa;
    if (idx >= 48 && idx <= 63) return phyData[63 - idx];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    prevA <= mdcA;
    if (!busyA) begin
      edgeA   <= 0;
      mdioInA <= 1'b1;
    end else if (!prevA && mdcA) begin
      capA.push_back({oeA, outA});
      mdioInA <= phyBit(edgeA + 1);
      edgeA   <= edgeA + 1;
    end
    if (rvA) validCntA <= validCntA + 1;
  end

  always @(negedge clk) begin
    prevB <= mdcB;
    if (busyB && !prevB && mdcB) capB.push_back({oeB, outB});
    if (rvB) validCntB <= validCntB + 1;
  end

  // Reference frame: whole frame as one vector, plus its drive-enable mask
  function automatic int frameErrs(input bit useB, input int offset, input bit pre,
                                   input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                                   input logic [15:0] d);
    logic [64:0] val;
    logic [64:0] oe;
    logic [1:0] c;
    int nb;
    int errs;
    val  = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), pa, ra, 2'b10, d, 1'b1};
    oe   = wr ? {64'hFFFF_FFFF_FFFF_FFFF, 1'b0} : {{46{1'b1}}, 19'b0};
    nb   = pre ? 65 : 33;
    errs = 0;
    for (int i = 0; i < nb; i++) begin
      int j;
      j = nb - 1 - i;
      if (offset + i >= (useB ? capB.size() : capA.size())) errs++;
      else begin
        c = useB ? capB[offset + i] : capA[offset + i];
        if (c[1] !== oe[j]) errs++;
        else if (oe[j] && c[0] !== val[j]) errs++;
      end
    end
    return errs;
  endfunction

  task automatic send(input bit sel, input bit wr, input logic [4:0] pa,
                      input logic [4:0] ra, input logic [15:0] d);
    @(negedge clk);
    for (int k = 0; k < 4000; k++) begin
      if (sel ? readyB : readyA) break;
      @(negedge clk);
    end
    if (sel) begin validB = 1'b1; wrB = wr; phyB = pa; regB = ra; wdB = d; end
    else     begin validA = 1'b1; wrA = wr; phyA = pa; regA = ra; wdA = d; end
    @(posedge clk);
    tAcc = $time;
    #1;
    if (sel) begin
      validB = 1'b0; wrB = 1'($urandom); phyB = 5'($urandom); regB = 5'($urandom); wdB = 16'($urandom);
    end else begin
      validA = 1'b0; wrA = 1'($urandom); phyA = 5'($urandom); regA = 5'($urandom); wdA = 16'($urandom);
    end
  endtask

  task automatic waitReady(input bit sel, output int lat);
    lat = -1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (sel ? readyB : readyA) begin
        lat = int'(($time - 5 - tAcc) / 10);
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    nChecks++;
    if ({readyA, busyA, mdcA, outA, oeA, rvA, errA, rdA} !== {7'b0001000, 16'h0000})
      $display("FAIL reset_pins: got %b expected %b", {readyA, busyA, mdcA, outA, oeA, rvA, errA, rdA},
               {7'b0001000, 16'h0000});
    else nPass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    nChecks++;
    if (readyA !== 1'b0) $display("FAIL ready_before_edge: got %b expected 0", readyA); else nPass++;
    @(posedge clk);
    #1;
    nChecks++;
    if (readyA !== 1'b1) $display("FAIL ready_after_release: got %b expected 1", readyA); else nPass++;
  endtask

  task automatic test_write;
    int lat;
    int v0;
    int e;
    capA.delete();
    v0 = validCntA;
    send(1'b0, 1'b1, 5'd1, 5'd0, 16'h1140);
    waitReady(1'b0, lat);
    nChecks++;
    if (lat !== NA) $display("FAIL write_latency: got %0d expected %0d", lat, NA); else nPass++;
    nChecks++;
    if (busyA !== 1'b0) $display("FAIL write_busy_end: got %b expected 0", busyA); else nPass++;
    nChecks++;
    if (capA.size() !== 65) $display("FAIL write_mdc_edges: got %0d expected 65", capA.size()); else nPass++;
    e = frameErrs(1'b0, 0, 1'b1, 1'b1, 5'd1, 5'd0, 16'h1140);
    nChecks++;
    if (e !== 0) $display("FAIL write_bits: got %0d bad bits expected 0", e); else nPass++;
    repeat (3) @(negedge clk);
    nChecks++;
    if (validCntA !== v0) $display("FAIL write_no_valid: got %0d pulses expected 0", validCntA - v0); else nPass++;
  endtask

  task automatic test_read_phy;
    int lat;
    int v0;
    int e;
    phyOn = 1'b1; phyTa = 1'b0; phyData = 16'hABCD;
    capA.delete();
    v0 = validCntA;
    send(1'b0, 1'b0, 5'd3, 5'd2, 16'h0);
    waitReady(1'b0, lat);
    nChecks++;
    if (lat !== NA) $display("FAIL read_latency: got %0d expected %0d", lat, NA); else nPass++;
    nChecks++;
    if ({rvA, errA, rdA} !== {2'b10, 16'hABCD})
      $display("FAIL read_result: got v=%b e=%b d=%h expected v=1 e=0 d=abcd", rvA, errA, rdA);
    else nPass++;
    e = frameErrs(1'b0, 0, 1'b1, 1'b0, 5'd3, 5'd2, 16'h0);
    nChecks++;
    if (e !== 0) $display("FAIL read_bits_oe: got %0d bad bits expected 0", e); else nPass++;
    repeat (3) @(negedge clk);
    nChecks++;
    if (validCntA - v0 !== 1) $display("FAIL read_pulses: got %0d expected 1", validCntA - v0); else nPass++;
    mdlRd = 16'hABCD;
  endtask

  task automatic test_read_nophy;
    int lat;
    int v0;
    phyOn = 1'b0;
    v0 = validCntA;
    send(1'b0, 1'b0, 5'd7, 5'd1, 16'h0);
    waitReady(1'b0, lat);
    nChecks++;
    if (lat !== NA) $display("FAIL nophy_latency: got %0d expected %0d", lat, NA); else nPass++;
    nChecks++;
    if ({rvA, errA, rdA} !== {2'b11, 16'hFFFF})
      $display("FAIL nophy_result: got v=%b e=%b d=%h expected v=1 e=1 d=ffff", rvA, errA, rdA);
    else nPass++;
    repeat (3) @(negedge clk);
    nChecks++;
    if (validCntA - v0 !== 1) $display("FAIL nophy_pulses: got %0d expected 1", validCntA - v0); else nPass++;
    mdlRd = 16'hFFFF;
  endtask

  task automatic test_random;
    for (int n = 0; n < 4; n++) begin
      int lat;
      int v0;
      int e;
      bit wr;
      logic [4:0] pa;
      logic [4:0] ra;
      logic [15:0] d;
      logic expErr;
      wr = 1'($urandom_range(0, 1));
      pa = 5'($urandom); ra = 5'($urandom); d = 16'($urandom);
      phyOn = 1'($urandom_range(0, 1)); phyTa = 1'($urandom_range(0, 1)); phyData = 16'($urandom);
      expErr = phyOn ? phyTa : 1'b1;
      if (!wr) mdlRd = phyOn ? phyData : 16'hFFFF;
      capA.delete();
      v0 = validCntA;
      send(1'b0, wr, pa, ra, d);
      waitReady(1'b0, lat);
      nChecks++;
      if (lat !== NA) $display("FAIL rand%0d_latency: got %0d expected %0d", n, lat, NA); else nPass++;
      nChecks++;
      if (rdA !== mdlRd) $display("FAIL rand%0d_rddata: got %h expected %h", n, rdA, mdlRd); else nPass++;
      if (!wr) begin
        nChecks++;
        if (errA !== expErr) $display("FAIL rand%0d_err: got %b expected %b", n, errA, expErr); else nPass++;
      end
      e = frameErrs(1'b0, 0, 1'b1, wr, pa, ra, d);
      nChecks++;
      if (e !== 0) $display("FAIL rand%0d_bits: got %0d bad bits expected 0", n, e); else nPass++;
      repeat (3) @(negedge clk);
      nChecks++;
      if (validCntA - v0 !== (wr ? 0 : 1))
        $display("FAIL rand%0d_pulses: got %0d expected %0d", n, validCntA - v0, wr ? 0 : 1);
      else nPass++;
    end
  endtask

  task automatic test_no_preamble;
    int lat;
    int e;
    int v0;
    logic [4:0] pa;
    logic [4:0] ra;
    logic [15:0] d;
    pa = 5'($urandom); ra = 5'($urandom); d = 16'($urandom);
    capB.delete();
    send(1'b1, 1'b1, pa, ra, d);
    @(negedge clk);
    nChecks++;
    if ({busyB, mdcB, oeB, outB} !== 4'b1010)
      $display("FAIL nopre_st_start: got %b expected 1010", {busyB, mdcB, oeB, outB});
    else nPass++;
    waitReady(1'b1, lat);
    nChecks++;
    if (lat !== NB) $display("FAIL nopre_wr_latency: got %0d expected %0d", lat, NB); else nPass++;
    nChecks++;
    if (capB.size() !== 33) $display("FAIL nopre_wr_edges: got %0d expected 33", capB.size()); else nPass++;
    e = frameErrs(1'b1, 0, 1'b0, 1'b1, pa, ra, d);
    nChecks++;
    if (e !== 0) $display("FAIL nopre_wr_bits: got %0d bad bits expected 0", e); else nPass++;
    capB.delete();
    v0 = validCntB;
    send(1'b1, 1'b0, ra, pa, 16'h0);
    waitReady(1'b1, lat);
    nChecks++;
    if (lat !== NB) $display("FAIL nopre_rd_latency: got %0d expected %0d", lat, NB); else nPass++;
    nChecks++;
    if ({rvB, errB, rdB} !== {2'b11, 16'hFFFF})
      $display("FAIL nopre_rd_result: got v=%b e=%b d=%h expected v=1 e=1 d=ffff", rvB, errB, rdB);
    else nPass++;
    e = frameErrs(1'b1, 0, 1'b0, 1'b0, ra, pa, 16'h0);
    nChecks++;
    if (e !== 0 || capB.size() !== 33)
      $display("FAIL nopre_rd_bits: got %0d bad bits %0d edges expected 0 and 33", e, capB.size());
    else nPass++;
    repeat (3) @(negedge clk);
    nChecks++;
    if (validCntB - v0 !== 1) $display("FAIL nopre_rd_pulses: got %0d expected 1", validCntB - v0); else nPass++;
  endtask

  task automatic test_back_to_back;
    int lat;
    int v0;
    int e1;
    int e2;
    logic [4:0] pa1, ra1, pa2, ra2;
    logic [15:0] d1;
    pa1 = 5'($urandom); ra1 = 5'($urandom); pa2 = 5'($urandom); ra2 = 5'($urandom);
    d1 = 16'($urandom);
    phyOn = 1'b1; phyTa = 1'b0; phyData = 16'($urandom);
    capA.delete();
    v0 = validCntA;
    @(negedge clk);
    for (int k = 0; k < 4000 && !readyA; k++) @(negedge clk);
    validA = 1'b1; wrA = 1'b1; phyA = pa1; regA = ra1; wdA = d1;
    @(posedge clk);
    tAcc = $time;
    #1;
    wrA = 1'b0; phyA = pa2; regA = ra2; wdA = 16'($urandom);
    waitReady(1'b0, lat);
    nChecks++;
    if (lat !== NA) $display("FAIL b2b_first_latency: got %0d expected %0d", lat, NA); else nPass++;
    nChecks++;
    if (mdcA !== 1'b0) $display("FAIL b2b_idle_mdc: got %b expected 0", mdcA); else nPass++;
    @(posedge clk);
    tAcc = $time;
    #1;
    validA = 1'b0;
    @(negedge clk);
    nChecks++;
    if ({busyA, readyA} !== 2'b10) $display("FAIL b2b_second_accept: got %b expected 10", {busyA, readyA}); else nPass++;
    waitReady(1'b0, lat);
    nChecks++;
    if (lat !== NA) $display("FAIL b2b_second_latency: got %0d expected %0d", lat, NA); else nPass++;
    nChecks++;
    if ({rvA, errA, rdA} !== {2'b10, phyData})
      $display("FAIL b2b_read_result: got v=%b e=%b d=%h expected v=1 e=0 d=%h", rvA, errA, rdA, phyData);
    else nPass++;
    nChecks++;
    if (capA.size() !== 130) $display("FAIL b2b_mdc_edges: got %0d expected 130", capA.size()); else nPass++;
    e1 = frameErrs(1'b0, 0, 1'b1, 1'b1, pa1, ra1, d1);
    e2 = frameErrs(1'b0, 65, 1'b1, 1'b0, pa2, ra2, 16'h0);
    nChecks++;
    if (e1 + e2 !== 0) $display("FAIL b2b_bits: got %0d bad bits expected 0", e1 + e2); else nPass++;
    repeat (3) @(negedge clk);
    nChecks++;
    if (validCntA - v0 !== 1) $display("FAIL b2b_pulses: got %0d expected 1", validCntA - v0); else nPass++;
    mdlRd = phyData;
  endtask

  task automatic test_reset_midframe;
    int lat;
    int v0;
    phyOn = 1'b1; phyTa = 1'b0; phyData = 16'($urandom);
    capA.delete();
    v0 = validCntA;
    send(1'b0, 1'b0, 5'd4, 5'd9, 16'h0);
    for (int k = 0; k < 2000 && capA.size() < 54; k++) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    nChecks++;
    if ({readyA, busyA, mdcA, outA, oeA, rvA, errA, rdA} !== {7'b0001000, 16'h0000})
      $display("FAIL midreset_pins: got %b expected %b", {readyA, busyA, mdcA, outA, oeA, rvA, errA, rdA},
               {7'b0001000, 16'h0000});
    else nPass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    nChecks++;
    if (readyA !== 1'b1) $display("FAIL midreset_ready: got %b expected 1", readyA); else nPass++;
    nChecks++;
    if (validCntA !== v0) $display("FAIL midreset_no_pulse: got %0d pulses expected 0", validCntA - v0); else nPass++;
    phyData = 16'($urandom);
    send(1'b0, 1'b0, 5'd4, 5'd9, 16'h0);
    waitReady(1'b0, lat);
    nChecks++;
    if (lat !== NA) $display("FAIL midreset_new_latency: got %0d expected %0d", lat, NA); else nPass++;
    nChecks++;
    if ({rvA, errA, rdA} !== {2'b10, phyData})
      $display("FAIL midreset_new_read: got v=%b e=%b d=%h expected v=1 e=0 d=%h", rvA, errA, rdA, phyData);
    else nPass++;
  endtask

  initial begin
    validA = 1'b0; wrA = 1'b0; phyA = 5'd0; regA = 5'd0; wdA = 16'h0;
    validB = 1'b0; wrB = 1'b0; phyB = 5'd0; regB = 5'd0; wdB = 16'h0;
    test_reset();
    test_write();
    test_read_phy();
    test_read_nophy();
    test_random();
    test_no_preamble();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdio_ctrl.md
# mdio_ctrl

Clause-22 MDIO management controller that configures and monitors the external RGMII PHY. It turns single register read/write requests into IEEE 802.3 Clause-22 management frames on MDC/MDIO and returns read data to the requester. It sits beside the RGMII MAC in the top level, driven by bring-up logic once the MMCMs lock and the PHY leaves reset. The MDIO pad tri-state is split into out, output-enable and in ports, and the top level builds the IOBUF.

## Interface
Parameters:
- CLK_DIV, 32: number of clkIn cycles per MDC half-period. MDC period = 2*CLK_DIV cycles. Minimum legal value is 4.
- PREAMBLE_EN, 1'b1: 1 sends a 32-bit all-ones preamble; 0 suppresses it (preamble suppression).

Ports:
- clkIn  input  1  single clock for all logic.
- rstIn  input  1  asynchronous, active-high reset.
- reqValidIn  input  1  request present.
- reqReadyOut  output  1  controller idle and able to accept a request.
- reqWrIn  input  1  1 = write, 0 = read.
- reqPhyAddrIn  input  5  PHY address.
- reqRegAddrIn  input  5  register address.
- reqWrDataIn  input  16  write data.
- rdDataOut  output  16  last read data.
- rdDataValidOut  output  1  one-cycle pulse marking completion of a read.
- rdErrOut  output  1  valid with rdDataValidOut: the PHY did not drive TA low.
- busyOut  output  1  frame in progress.
- mdClkOut  output  1  MDC.
- mdioOut  output  1  MDIO output value.
- mdioOeOut  output  1  MDIO output enable, 1 = drive.
- mdioIn  input  1  MDIO pad input. Asynchronous; passes through a 2-flop synchronizer inside the block.

## Operation
- Handshake: a request is accepted on the cycle where reqValidIn & reqReadyOut are both 1. All request fields are latched on that cycle. reqReadyOut falls on the next cycle and stays low until the frame completes.
- Frame, MSB first, one bit per MDC period:
  - PREAMBLE: 32 bits of 1. This state is skipped when PREAMBLE_EN=0.
  - HDR: 14 bits = ST 01, OP (01 write / 10 read), PHYAD[4:0], REGAD[4:0].
  - TA: 2 bits.
    - Write: drive 1 then 0.
    - Read: mdioOeOut=0 for both bits. The second TA bit is sampled; a sampled 1 sets the error flag.
  - DATA: 16 bits.
    - Write: drive reqWrDataIn[15:0].
    - Read: mdioOeOut=0; sample into a shift register.
  - IDLE_BIT: 1 bit with mdioOeOut=0 and MDC still toggling.
  - Return to IDLE.
- FSM states: IDLE, PREAMBLE, HDR, TA, DATA, IDLE_BIT. A 5-bit bit counter indexes bits within each state.
- Read completion: a read captures all 16 bits regardless of the error flag. An unpopulated PHY reads as 0xFFFF with rdErrOut=1.
- Outputs in IDLE: mdClkOut=0, mdioOeOut=0, mdioOut=1.
- rdDataOut holds its value until the next read completes. Writes never change rdDataOut or pulse rdDataValidOut.
- busyOut = (state != IDLE).

## Timing
- Reset values (asserted asynchronously, held while rstIn=1):
  - reqReadyOut=0, busyOut=0, mdClkOut=0, mdioOut=1, mdioOeOut=0.
  - rdDataOut=16'h0000, rdDataValidOut=0, rdErrOut=0.
  - reqReadyOut rises on the first clkIn edge after rstIn deasserts.
- Bit period: each bit is CLK_DIV cycles with mdClkOut=0 followed by CLK_DIV cycles with mdClkOut=1.
- Drive edge: mdioOut and mdioOeOut change only on the cycle mdClkOut falls, i.e. the first low-phase cycle. The PHY samples on the MDC rising edge, and setup is CLK_DIV-1 cycles.
- Read sample point: the synchronized mdioIn is sampled on the last low-phase cycle of each bit, just before MDC rises. This allows for the 2-cycle synchronizer delay and the PHY clock-to-out delay of up to 300 ns, which is met when CLK_DIV*Tclk ≥ 300 ns + 3 Tclk.
- Latency, with acceptance at cycle t:
  - Bit 0 low phase begins at t+1.
  - Frame length N = B*2*CLK_DIV cycles, where B=65 with preamble and B=33 without.
  - At cycle t+1+N: busyOut=0, reqReadyOut=1, and rdDataValidOut=1 for one cycle on reads, with rdDataOut/rdErrOut updated in that same cycle.
- Back-to-back: a request held valid is accepted at t+1+N, so the next frame starts at t+2+N. MDC stays low for exactly that one idle cycle.
- Reset mid-frame: the frame is aborted immediately and the pins go to their reset values. No rdDataValidOut pulse is produced, and the latched request is discarded.
- reqValidIn while busy is ignored. Request fields may change freely while reqReadyOut=0.

## Test plan
- Write, CLK_DIV=4, PREAMBLE_EN=1: request phy=1, reg=0, data=0x1140. MDIO bits decoded on MDC rising edges must equal 32×1, 01 01 00001 00000 10 0001000101000000. 65 MDC periods. reqReadyOut high again exactly 521 cycles after acceptance. No rdDataValidOut pulse.
- Read with PHY model: phy=3, reg=2; the model drives 0 in TA bit 2 and then 0xABCD. Expect mdioOeOut=0 from the first TA bit through IDLE_BIT. Expect one rdDataValidOut pulse with rdDataOut=0xABCD, rdErrOut=0.
- Read with no PHY (mdioIn pulled to 1): expect rdDataOut=0xFFFF, rdErrOut=1, single valid pulse.
- PREAMBLE_EN=0: any request yields 33 MDC periods. Frame starts with ST=01 immediately after acceptance.
- Back-to-back: reqValidIn held high with two queued requests (write then read). The second is accepted on the same cycle reqReadyOut rises. MDC has one low idle cycle between frames, and no MDC edges are lost or duplicated.
- Reset mid-frame: assert rstIn during DATA bit 5 of a read. Pins go to reset values asynchronously with no valid pulse. After release, reqReadyOut=1 next cycle and a new read returns correct data.
